// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory access controller.
// The MEM_ACCESS_RMW_EN macro adds the read-modify-write states used for sub-word stores.
package mem_access_pkg;

  localparam int DEFAULT_MEM_LATENCY = 10;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READ      = 3'd1,
    WRITE     = 3'd2,
    DONE      = 3'd3
`ifdef MEM_ACCESS_RMW_EN
    ,
    RMW_READ  = 3'd4,
    RMW_WRITE = 3'd5
`endif
  } state_e;

  // The illegal size encoding is rejected here as well, so callers need only one test.
  function automatic logic is_misaligned(size_e size, logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return addr_lo[0];
      SIZE_WORD: return (addr_lo != 2'b00);
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-memory port of the access controller; master is the controller, slave the memory.
interface mem_access_ctrl_if;

  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (output mem_read, mem_write, mem_address, mem_wdata, input mem_rdata);
  modport slave  (input mem_read, mem_write, mem_address, mem_wdata, output mem_rdata);

endinterface

// File: rtl/mem_lane_align.sv
// Little-endian byte-lane handling: load extraction with sign/zero extension
// and store merging of a sub-word into an existing memory word.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  size_e       size,
  input  logic        is_unsigned,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] mem_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel   = mem_word[{addr_lo, 3'b000} +: 8];
    half_sel   = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];
    load_data  = mem_word;
    merge_data = store_data;
    case (size)
      SIZE_BYTE: begin
        load_data  = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        merge_data = mem_word;
        merge_data[{addr_lo, 3'b000} +: 8] = store_data[7:0];
      end
      SIZE_HALF: begin
        load_data  = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
        merge_data = addr_lo[1] ? {store_data[15:0], mem_word[15:0]}
                                : {mem_word[31:16], store_data[15:0]};
      end
      default: begin
        load_data  = mem_word;
        merge_data = store_data;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller holding each memory access for MEM_LATENCY cycles.
// Define MEM_ACCESS_RMW_EN to support sub-word stores by read-modify-write.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int MEM_LATENCY = DEFAULT_MEM_LATENCY
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              stall,
  mem_access_ctrl_if.master mem
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               write_q, write_d;
  size_e              size_q, size_d;
  logic               unsigned_q, unsigned_d;
  logic               err_q, err_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [31:0]        load_data;
  logic [31:0]        merge_data;

  mem_lane_align u_align (
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .addr_lo     (addr_q[1:0]),
    .mem_word    (rdata_q),
    .store_data  (wdata_q),
    .load_data   (load_data),
    .merge_data  (merge_data)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      write_q    <= 1'b0;
      size_q     <= SIZE_BYTE;
      unsigned_q <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      write_q    <= write_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    write_d    = write_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    err_d      = err_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d    = req_write;
          size_d     = size_e'(req_size);
          unsigned_d = req_unsigned;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          rdata_d    = '0;
          cnt_d      = CNT_LOAD;
          err_d      = is_misaligned(size_e'(req_size), req_addr[1:0]);
          if (err_d) begin
            state_d = DONE;
          end else if (!req_write) begin
            state_d = READ;
          end else if (size_e'(req_size) == SIZE_WORD) begin
            state_d = WRITE;
          end else begin
`ifdef MEM_ACCESS_RMW_EN
            state_d = RMW_READ;
`else
            err_d   = 1'b1;
            state_d = DONE;
`endif
          end
        end
      end
      READ: begin
        if (cnt_q == '0) begin
          rdata_d = mem.mem_rdata;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WRITE: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
`ifdef MEM_ACCESS_RMW_EN
      RMW_READ: begin
        if (cnt_q == '0) begin
          rdata_d = mem.mem_rdata;
          cnt_d   = CNT_LOAD;
          state_d = RMW_WRITE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RMW_WRITE: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory strobes decode straight from state so reset drops them without waiting for a clock.
  always_comb begin
    mem.mem_read  = (state_q == READ);
    mem.mem_write = (state_q == WRITE);
`ifdef MEM_ACCESS_RMW_EN
    mem.mem_read  = mem.mem_read  || (state_q == RMW_READ);
    mem.mem_write = mem.mem_write || (state_q == RMW_WRITE);
`endif
    mem.mem_address = {2'b00, addr_q[31:2]};
    mem.mem_wdata   = mem.mem_write ? merge_data : 32'h0;
    req_ready       = (state_q == IDLE);
    resp_valid      = (state_q == DONE);
    resp_err        = resp_valid && err_q;
    resp_rdata      = (resp_valid && !err_q && !write_q) ? load_data : 32'h0;
    stall           = ((state_q == IDLE) && req_valid) ||
                      ((state_q != IDLE) && (state_q != DONE));
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl; expectations follow MEM_ACCESS_RMW_EN when it is defined.
module tb_mem_access_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall;

  int errCount = 0;
  int checkCount = 0;

  mem_access_ctrl_if mem_bus ();

  mem_access_ctrl #(.MEM_LATENCY(10)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .stall        (stall),
    .mem          (mem_bus.master)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] memWord;
    logic        expErr;
    logic [31:0] expRdata;
    int          expLat;
    logic        expRead;
    logic        expWrite;
    logic [31:0] expWdata;
  } vec_t;

  vec_t vecs[13];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clock);
    mem_bus.mem_rdata = v.memWord;
    req_write    = v.wr;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    req_valid    = 1'b1;
    #1;
    checkOutput({v.name, ".stall_c0"}, 32'(stall), 32'd1);
    checkOutput({v.name, ".ready_c0"}, 32'(req_ready), 32'd1);
    @(posedge clock);
    #1;
    // Garbage on the request bus while busy must not disturb the transaction.
    req_write = ~v.wr;
    req_size  = 2'b10;
    req_addr  = ~v.addr;
    req_wdata = 32'h0BAD0BAD;
  endtask

  task automatic runVector(input vec_t v);
    int   cyc;
    logic sawRead, sawWrite, bothHigh, addrBad, gotResp;
    logic [31:0] lastWdata;
    applyStimulus(v);
    cyc = 1;
    sawRead = 0; sawWrite = 0; bothHigh = 0; addrBad = 0; gotResp = 0;
    lastWdata = '0;
    while (cyc <= 100) begin
      if (mem_bus.mem_read) sawRead = 1;
      if (mem_bus.mem_write) begin
        sawWrite  = 1;
        lastWdata = mem_bus.mem_wdata;
      end
      if (mem_bus.mem_read && mem_bus.mem_write) bothHigh = 1;
      if ((mem_bus.mem_read || mem_bus.mem_write) && mem_bus.mem_address !== (v.addr >> 2))
        addrBad = 1;
      if (resp_valid) begin
        gotResp = 1;
        break;
      end
      @(posedge clock);
      #1;
      cyc++;
    end
    checkOutput({v.name, ".resp_seen"}, 32'(gotResp), 32'd1);
    checkOutput({v.name, ".latency"}, 32'(cyc), 32'(v.expLat));
    checkOutput({v.name, ".err"}, 32'(resp_err), 32'(v.expErr));
    checkOutput({v.name, ".rdata"}, resp_rdata, v.expRdata);
    checkOutput({v.name, ".stall_done"}, 32'(stall), 32'd0);
    checkOutput({v.name, ".mem_read_seen"}, 32'(sawRead), 32'(v.expRead));
    checkOutput({v.name, ".mem_write_seen"}, 32'(sawWrite), 32'(v.expWrite));
    checkOutput({v.name, ".both_high"}, 32'(bothHigh), 32'd0);
    checkOutput({v.name, ".addr_stable"}, 32'(addrBad), 32'd0);
    if (v.expWrite) checkOutput({v.name, ".mem_wdata"}, lastWdata, v.expWdata);
    req_valid = 1'b0;
    @(posedge clock);
    #1;
    checkOutput({v.name, ".ready_after"}, 32'(req_ready), 32'd1);
    checkOutput({v.name, ".resp_pulse"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    int noResp;
    vecs[0]  = '{"word_load",    1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 11, 1'b1, 1'b0, 32'h0};
    vecs[1]  = '{"sbyte_load",   1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h80FF1234, 1'b0, 32'hFFFFFF80, 11, 1'b1, 1'b0, 32'h0};
    vecs[2]  = '{"ubyte_load",   1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h80FF1234, 1'b0, 32'h00000080, 11, 1'b1, 1'b0, 32'h0};
    vecs[3]  = '{"shalf_load",   1'b0, 2'b01, 1'b0, 32'h02, 32'h0, 32'h80FF1234, 1'b0, 32'hFFFF80FF, 11, 1'b1, 1'b0, 32'h0};
    vecs[4]  = '{"uhalf_load",   1'b0, 2'b01, 1'b1, 32'h00, 32'h0, 32'h80FF1234, 1'b0, 32'h00001234, 11, 1'b1, 1'b0, 32'h0};
    vecs[5]  = '{"sbyte_pos",    1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'h80FF1234, 1'b0, 32'h00000012, 11, 1'b1, 1'b0, 32'h0};
    vecs[6]  = '{"half_misal",   1'b0, 2'b01, 1'b0, 32'h05, 32'h0, 32'h80FF1234, 1'b1, 32'h0, 1, 1'b0, 1'b0, 32'h0};
    vecs[7]  = '{"word_misal",   1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 32'h80FF1234, 1'b1, 32'h0, 1, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{"size_illegal", 1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 32'h80FF1234, 1'b1, 32'h0, 1, 1'b0, 1'b0, 32'h0};
    vecs[9]  = '{"word_store",   1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, 32'h11223344, 1'b0, 32'h0, 11, 1'b0, 1'b1, 32'hCAFEF00D};
    vecs[10] = '{"store_misal",  1'b1, 2'b10, 1'b0, 32'h23, 32'hCAFEF00D, 32'h11223344, 1'b1, 32'h0, 1, 1'b0, 1'b0, 32'h0};
`ifdef MEM_ACCESS_RMW_EN
    vecs[11] = '{"byte_store",   1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AB, 32'h11223344, 1'b0, 32'h0, 21, 1'b1, 1'b1, 32'h1122AB44};
    vecs[12] = '{"half_store",   1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFF5566, 32'h11223344, 1'b0, 32'h0, 21, 1'b1, 1'b1, 32'h55663344};
`else
    vecs[11] = '{"byte_store",   1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AB, 32'h11223344, 1'b1, 32'h0, 1, 1'b0, 1'b0, 32'h0};
    vecs[12] = '{"half_store",   1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFF5566, 32'h11223344, 1'b1, 32'h0, 1, 1'b0, 1'b0, 32'h0};
`endif
    mem_bus.mem_rdata = '0;

    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset.ready", 32'(req_ready), 32'd1);
    checkOutput("reset.resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("reset.resp_rdata", resp_rdata, 32'h0);
    checkOutput("reset.mem_rw", {30'h0, mem_bus.mem_read, mem_bus.mem_write}, 32'h0);
    checkOutput("reset.stall", 32'(stall), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 13; i++) runVector(vecs[i]);

    // Reset in the middle of a word store: strobe drops at once and no response follows.
    applyStimulus('{"rst_store", 1'b1, 2'b10, 1'b0, 32'h40, 32'h12345678, 32'h0, 1'b0, 32'h0, 11, 1'b0, 1'b1, 32'h12345678});
    req_valid = 1'b0;
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    checkOutput("rst.write_before", 32'(mem_bus.mem_write), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("rst.write_now", 32'(mem_bus.mem_write), 32'd0);
    checkOutput("rst.ready_now", 32'(req_ready), 32'd1);
    checkOutput("rst.stall_now", 32'(stall), 32'd0);
    noResp = 0;
    repeat (3) begin
      @(posedge clock);
      #1;
      if (resp_valid) noResp++;
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (15) begin
      @(posedge clock);
      #1;
      if (resp_valid || mem_bus.mem_write) noResp++;
    end
    checkOutput("rst.no_resp", 32'(noResp), 32'd0);
    runVector(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter MEM_LATENCY, default 10, meaning cycles a request is held on the memory port before completion (min 1).
REQ-002 clock  input  1  system clock, rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  pipeline requests a load/store.
REQ-005 req_write  input  1  1=store, 0=load.
REQ-006 req_size  input  2  00 byte, 01 halfword, 10 word; 11 is illegal.
REQ-007 req_unsigned  input  1  zero-extend sub-word loads when 1, sign-extend when 0.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 req_ready  output  1  high only in IDLE.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  extended load result; 0 for stores and errors.
REQ-013 resp_err  output  1  qualifies resp_valid; misaligned or illegal request.
REQ-014 stall  output  1  freezes the pipeline.
REQ-015 mem_read, mem_write  output  1 each  to data memory.
REQ-016 mem_address  output  32  word index, req_addr>>2.
REQ-017 mem_wdata  output  32  full word to memory.
REQ-018 mem_rdata  input  32  word from memory.

Function
REQ-019 FSM states SHALL be IDLE, READ, WRITE, RMW_READ, RMW_WRITE, DONE.
REQ-020 IDLE: req_valid accepted in the same cycle; request fields latched internally.
REQ-021 Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size 11 SHALL go to DONE without asserting mem_read/mem_write, resp_err=1.
REQ-022 Load/word store SHALL go to READ/WRITE; sub-word store to RMW_READ.
REQ-023 READ/WRITE/RMW_READ/RMW_WRITE each SHALL hold mem_read or mem_write high with stable mem_address/mem_wdata for exactly MEM_LATENCY cycles, counted by a down-counter.
REQ-024 mem_rdata SHALL be captured on the last cycle of READ and RMW_READ.
REQ-025 Byte lanes little-endian: byte at addr[1:0]=0 in bits 7:0; halfword at addr[1]=0 in bits 15:0.
REQ-026 RMW_WRITE SHALL write the captured word with only the addressed lane(s) replaced by req_wdata low bits.
REQ-027 DONE lasts one cycle, drives resp_valid=1, then returns to IDLE.
REQ-028 Latency accept->resp_valid: load/word store MEM_LATENCY+1; sub-word store 2*MEM_LATENCY+1; error 1.
REQ-029 stall = req_valid in IDLE, or state not IDLE/DONE; low in DONE.
REQ-030 mem_read and mem_write SHALL never be high together.
REQ-031 req_valid or field changes while not IDLE SHALL be ignored.

Reset
REQ-032 reset low SHALL immediately force IDLE, counter 0, mem_read=mem_write=0, resp_valid=0, resp_err=0, resp_rdata=0, internal latches 0, including mid-operation.
REQ-033 No response SHALL be issued for a request aborted by reset.

Configuration
REQ-034 Macro MEM_ACCESS_RMW_EN: defined -> sub-word stores use RMW_READ/RMW_WRITE; undefined -> sub-word stores complete via DONE with resp_err=1 and no memory access, RMW states absent.

Structure
REQ-035 Package mem_access_pkg SHALL hold size encodings, FSM state enum, default MEM_LATENCY.
REQ-036 Sub-module mem_lane_align (combinational) SHALL do lane extract/extend for loads and lane merge for stores.

Verification
REQ-037 Word load addr 0x10, mem_rdata 0xDEADBEEF -> mem_address 4, resp_valid at cycle 11, resp_rdata 0xDEADBEEF, resp_err 0.
REQ-038 Signed byte load addr 0x13, word 0x80FF1234 -> resp_rdata 0xFFFFFF80; unsigned -> 0x00000080.
REQ-039 Byte store 0xAB to addr 0x21, memory word 0x11223344 (RMW_EN) -> mem_wdata 0x1122AB44, resp_valid at cycle 21.
REQ-040 Halfword load addr 0x05 -> resp_valid next cycle, resp_err 1, mem_read never high.
REQ-041 reset low on cycle 4 of a word store -> mem_write 0 immediately, no resp_valid, next request serviced normally.
REQ-042 Byte store without MEM_ACCESS_RMW_EN -> resp_err 1 at cycle 1, no memory write.
